pick_fifo_ll: RTL and testbench
===============================

Name: pick_fifo_ll

Overview:
- Shared-buffer multi-flow FIFO. One write port carries tagged words; each flow is read independently in per-flow FIFO order.
- Flows share one DEPTH-entry RAM. Each flow is kept as a linked list, and unused entries sit on a free-list queue.
- Adds what the earlier pick FIFO lacked: a per-flow occupancy cap, registered read data with valid and flow-ID qualifiers, explicit drop reporting and an occupancy count.
- Sits between the tag-multiplexing producer and the per-flow dataflow consumers.

Parameters:
- WIDTH, 8: total word width; the top TAG_WIDTH bits are the flow tag.
- DEPTH, 8: shared entries; must be at least 2. Need not be a power of 2.
- FLUX, 2: number of flows; must be at least 2.
- MAX_PER_FLOW, DEPTH: per-flow occupancy cap; range 1..DEPTH.
- TAG_WIDTH (localparam), $clog2(FLUX): tag field width.
- ADDR_WIDTH (localparam), $clog2(DEPTH): entry index width.
- CNT_WIDTH (localparam), $clog2(DEPTH+1): counter width.

Ports:
- ck  in  1  clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr  in  1  write request.
- datain  in  WIDTH  write word; flow tag = datain[WIDTH-1 -: TAG_WIDTH].
- rd  in  FLUX  per-flow read requests.
- full  out  1  all DEPTH entries occupied.
- empty  out  FLUX  flow i holds no entries.
- flow_full  out  FLUX  flow i count == MAX_PER_FLOW.
- dataout  out  WIDTH  read data, registered.
- dout_valid  out  1  dataout holds a word popped on the previous cycle.
- dout_flow  out  TAG_WIDTH  flow that dataout belongs to.
- wr_drop  out  1  one-cycle pulse: last cycle's write was rejected.
- count  out  CNT_WIDTH  total occupied entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - Free-list queue loaded with 0..DEPTH-1; free count = DEPTH.
  - All per-flow head, tail and count = 0.
  - Outputs: full=0, empty=all 1s, flow_full=0, dataout=0, dout_valid=0, dout_flow=0, wr_drop=0, count=0.
  - RAM and link contents are not reset.
- Release: reset deasserts asynchronously. The first active edge after rst=1 behaves normally.
- Status timing: full, empty, flow_full and count are registered and reflect state at the start of the cycle. All accept decisions use these start-of-cycle values.
- Write accept: wr=1, full=0, tag<FLUX and flow_full[tag]=0.
  - Pop free-list head E; write datain to RAM[E].
  - If the flow is empty, set head=tail=E. Otherwise set link[tail]=E, then tail=E.
  - Increment the flow count.
- Write reject: any accept condition fails while wr=1.
  - No state change.
  - wr_drop=1 on the next cycle, for one cycle.
  - Tags >= FLUX (FLUX not a power of 2) are always rejected.
- Read select: the winner is the highest index i with rd[i]=1 and empty[i]=0. At most one pop per cycle. Losing requests are ignored, not queued.
- Read accept (winner i, entry H=head[i]):
  - On the next edge: dataout=RAM[H], dout_flow=i, dout_valid=1.
  - If count[i]>1, head[i]=link[H].
  - Decrement count[i] and push H onto the free-list tail.
- No winner: dout_valid=0 next cycle; dataout and dout_flow hold their values.
- Read latency: 1 cycle from request to dout_valid.
- Simultaneous write and read, same cycle:
  - Both may be accepted. The free list pushes and pops in the same cycle, and count is unchanged.
  - When full=1, the write is rejected even if a read frees an entry in that cycle; no same-cycle bypass.
  - A read of flow i with empty[i]=1 is never accepted, even if a write to flow i lands in that cycle. That data becomes readable from the next cycle.
  - A read and a write to the same non-empty flow update head and tail independently. For count[i]==1, the new entry becomes the head and tail (head <= E).
- Wrap-around: free-list pointers wrap modulo DEPTH. Free-list occupancy is tracked by the free count, not by pointer equality.
- Invariant: sum of flow counts + free count == DEPTH at every edge. The verification engineer asserts this continuously.
- Reset mid-operation discards all stored data immediately. dout_valid falls asynchronously.
- No combinational path from inputs to any output.

Test Plan:
1. Reset, then write 0x01, 0x82, 0x03, 0x84 (tags 0,1,0,1), then rd=2'b01 for two cycles, then rd=2'b10 for two cycles.
   -> dataout 0x01, 0x03 with dout_flow=0, then 0x82, 0x84 with dout_flow=1. Each has dout_valid=1 one cycle after its rd. empty=2'b11 at the end.
2. Config DEPTH=8, MAX_PER_FLOW=6. Write six tag-0 words, then a seventh.
   -> flow_full[0]=1, wr_drop=1 on the cycle after the seventh write, count=6.
   Then two tag-1 writes -> full=1. A further write -> wr_drop=1.
3. Hold full, assert wr=1 with tag 1 and rd=2'b01 in the same cycle.
   -> write dropped, one word popped, count=7.
   Next cycle, repeat the write -> accepted, count=8.
4. Set rd=2'b11 with both flows non-empty.
   -> flow 1 popped, dout_flow=1, flow 0 count unchanged.
   Set rd=2'b01 while flow 0 is empty -> dout_valid=0.
5. Run 10000 random wr/rd cycles against a per-flow queue model.
   -> data order, dout_flow and drop pulses match the model; the count-sum invariant is never violated; the free list wraps at least 100 times.
6. Assert rst=0 mid-burst, between clock edges.
   -> outputs reach reset values immediately. After release, writing 0x05 and reading flow 0 returns 0x05 with no stale data.

Source files
------------

// File: rtl/pick_fifo_ll_if.sv
// pick_fifo_ll_if: write/read/status bundle of the shared-buffer multi-flow FIFO
interface pick_fifo_ll_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int FLUX  = 2
);
  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  logic                 wr;
  logic [WIDTH-1:0]     datain;
  logic [FLUX-1:0]      rd;
  logic                 full;
  logic [FLUX-1:0]      empty;
  logic [FLUX-1:0]      flow_full;
  logic [WIDTH-1:0]     dataout;
  logic                 dout_valid;
  logic [TAG_WIDTH-1:0] dout_flow;
  logic                 wr_drop;
  logic [CNT_WIDTH-1:0] count;
  modport master (output wr, datain, rd,
                  input  full, empty, flow_full, dataout, dout_valid, dout_flow, wr_drop, count);
  modport slave  (input  wr, datain, rd,
                  output full, empty, flow_full, dataout, dout_valid, dout_flow, wr_drop, count);
endinterface

// File: rtl/pick_fifo_ll.sv
// pick_fifo_ll: shared-buffer multi-flow FIFO, per-flow linked lists over one RAM plus a free-list queue
module pick_fifo_ll #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 8,
  parameter int FLUX         = 2,
  parameter int MAX_PER_FLOW = DEPTH
) (
  input logic            ck,
  input logic            rst,
  pick_fifo_ll_if.slave  bus
);
  localparam int TAG_WIDTH  = $clog2(FLUX);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]      r_ram  [DEPTH];
  logic [ADDR_WIDTH-1:0] r_link [DEPTH];
  logic [ADDR_WIDTH-1:0] r_free [DEPTH];
  logic [ADDR_WIDTH-1:0] r_fhead, r_ftail;
  logic [CNT_WIDTH-1:0]  r_fcnt;
  logic [ADDR_WIDTH-1:0] r_head [FLUX];
  logic [ADDR_WIDTH-1:0] r_tail [FLUX];
  logic [CNT_WIDTH-1:0]  r_cnt  [FLUX];
  logic                  r_full;
  logic [FLUX-1:0]       r_empty, r_flow_full;
  logic [WIDTH-1:0]      r_dataout;
  logic                  r_dout_valid;
  logic [TAG_WIDTH-1:0]  r_dout_flow;
  logic                  r_wr_drop;
  logic [CNT_WIDTH-1:0]  r_count;

  logic [TAG_WIDTH-1:0]  w_tag, w_win;
  logic                  w_wr_ok, w_rd_ok;
  logic [ADDR_WIDTH-1:0] w_e, w_h;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt [FLUX];
  logic [CNT_WIDTH-1:0]  w_fcnt_nxt;

  // Accept decisions from start-of-cycle status; highest requesting non-empty flow wins the read
  always_comb begin
    w_tag   = bus.datain[WIDTH-1 -: TAG_WIDTH];
    w_wr_ok = bus.wr && !r_full && (int'(w_tag) < FLUX) && !r_flow_full[w_tag];
    w_rd_ok = 1'b0;
    w_win   = '0;
    for (int i = 0; i < FLUX; i++)
      if (bus.rd[i] && !r_empty[i]) begin
        w_rd_ok = 1'b1;
        w_win   = TAG_WIDTH'(i);
      end
    w_e = r_free[r_fhead];
    w_h = r_head[w_win];
    for (int f = 0; f < FLUX; f++)
      w_cnt_nxt[f] = r_cnt[f] + CNT_WIDTH'(w_wr_ok && w_tag == TAG_WIDTH'(f))
                              - CNT_WIDTH'(w_rd_ok && w_win == TAG_WIDTH'(f));
    w_fcnt_nxt = r_fcnt - CNT_WIDTH'(w_wr_ok) + CNT_WIDTH'(w_rd_ok);
  end

  // Data RAM and next-links; stale contents are never observable, so no reset
  always_ff @(posedge ck) begin
    if (w_wr_ok) r_ram[w_e] <= bus.datain;
    if (w_wr_ok && r_cnt[w_tag] != '0) r_link[r_tail[w_tag]] <= w_e;
  end

  // Free list, per-flow list pointers, registered status and read data
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_free[i] <= ADDR_WIDTH'(i);
      r_fhead <= '0;
      r_ftail <= '0;
      r_fcnt  <= CNT_WIDTH'(DEPTH);
      for (int f = 0; f < FLUX; f++) begin
        r_head[f] <= '0;
        r_tail[f] <= '0;
        r_cnt[f]  <= '0;
      end
      r_full       <= 1'b0;
      r_empty      <= '1;
      r_flow_full  <= '0;
      r_dataout    <= '0;
      r_dout_valid <= 1'b0;
      r_dout_flow  <= '0;
      r_wr_drop    <= 1'b0;
      r_count      <= '0;
    end else begin
      if (w_wr_ok) r_fhead <= (r_fhead == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_fhead + 1'b1;
      if (w_rd_ok) begin
        r_free[r_ftail] <= w_h;
        r_ftail         <= (r_ftail == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_ftail + 1'b1;
        r_dataout       <= r_ram[w_h];
        r_dout_flow     <= w_win;
      end
      for (int f = 0; f < FLUX; f++) begin
        if (w_wr_ok && w_tag == TAG_WIDTH'(f)) begin
          r_tail[f] <= w_e;
          if (r_cnt[f] == '0 || (w_rd_ok && w_win == TAG_WIDTH'(f) && r_cnt[f] == CNT_WIDTH'(1)))
            r_head[f] <= w_e;
          else if (w_rd_ok && w_win == TAG_WIDTH'(f))
            r_head[f] <= r_link[w_h];
        end else if (w_rd_ok && w_win == TAG_WIDTH'(f) && r_cnt[f] > CNT_WIDTH'(1))
          r_head[f] <= r_link[w_h];
        r_cnt[f]       <= w_cnt_nxt[f];
        r_empty[f]     <= w_cnt_nxt[f] == '0;
        r_flow_full[f] <= w_cnt_nxt[f] == CNT_WIDTH'(MAX_PER_FLOW);
      end
      r_fcnt       <= w_fcnt_nxt;
      r_full       <= w_fcnt_nxt == '0;
      r_count      <= CNT_WIDTH'(DEPTH) - w_fcnt_nxt;
      r_dout_valid <= w_rd_ok;
      r_wr_drop    <= bus.wr && !w_wr_ok;
    end
  end

  assign bus.full       = r_full;
  assign bus.empty      = r_empty;
  assign bus.flow_full  = r_flow_full;
  assign bus.dataout    = r_dataout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout_flow  = r_dout_flow;
  assign bus.wr_drop    = r_wr_drop;
  assign bus.count      = r_count;
endmodule

// File: tb/tb_pick_fifo_ll.sv
// tb_pick_fifo_ll: scoreboard bench for pick_fifo_ll (DEPTH=8, FLUX=2, MAX_PER_FLOW=6)
module tb_pick_fifo_ll;
  logic ck = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  pick_fifo_ll_if #(.WIDTH(8), .DEPTH(8), .FLUX(2)) bus ();
  pick_fifo_ll #(.WIDTH(8), .DEPTH(8), .FLUX(2), .MAX_PER_FLOW(6)) dut (.ck(ck), .rst(rst), .bus(bus));

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       f;
    logic       drop;
  } exp_t;

  exp_t       sq [$];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int checks = 0;
  int fails  = 0;
  int wraps  = 0;
  logic [2:0] prev_fh = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus issued at a falling edge; the model predicts the response and queues it
  task automatic cycle(input logic w, input logic [7:0] d, input logic [1:0] r);
    exp_t e;
    logic acc;
    bus.wr = w;
    bus.datain = d;
    bus.rd = r;
    acc = w && (q0.size() + q1.size() < 8) && ((d[7] ? q1.size() : q0.size()) < 6);
    e = '0;
    e.drop = w && !acc;
    if (r[1] && q1.size() > 0) begin
      e.v = 1'b1; e.f = 1'b1; e.d = q1.pop_front();
    end else if (r[0] && q0.size() > 0) begin
      e.v = 1'b1; e.f = 1'b0; e.d = q0.pop_front();
    end
    if (acc) begin
      if (d[7]) q1.push_back(d);
      else q0.push_back(d);
    end
    sq.push_back(e);
    @(posedge ck);
    @(negedge ck);
    bus.wr = 1'b0;
    bus.rd = '0;
  endtask

  // Monitor: just after each edge, pop one expectation and compare; also watch the occupancy invariant
  initial forever begin
    exp_t e;
    @(posedge ck);
    #1;
    if (rst) begin
      chk("invariant", int'(dut.r_cnt[0]) + int'(dut.r_cnt[1]) + int'(dut.r_fcnt), 8);
      if (prev_fh == 3'd7 && dut.r_fhead == 3'd0) wraps++;
      prev_fh = dut.r_fhead;
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("dout_valid", int'(bus.dout_valid), int'(e.v));
        chk("wr_drop", int'(bus.wr_drop), int'(e.drop));
        if (e.v && bus.dout_valid) begin
          chk("dataout", int'(bus.dataout), int'(e.d));
          chk("dout_flow", int'(bus.dout_flow), int'(e.f));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr = 1'b0;
    bus.datain = '0;
    bus.rd = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge ck);
    rst = 1'b1;
    chk("rst full", int'(bus.full), 0);
    chk("rst empty", int'(bus.empty), 3);
    chk("rst flow_full", int'(bus.flow_full), 0);
    chk("rst dataout", int'(bus.dataout), 0);
    chk("rst dout_valid", int'(bus.dout_valid), 0);
    chk("rst dout_flow", int'(bus.dout_flow), 0);
    chk("rst wr_drop", int'(bus.wr_drop), 0);
    chk("rst count", int'(bus.count), 0);

    // Interleaved flows come back in per-flow order
    cycle(1, 8'h01, 0); cycle(1, 8'h82, 0); cycle(1, 8'h03, 0); cycle(1, 8'h84, 0);
    chk("t1 count", int'(bus.count), 4);
    cycle(0, 0, 2'b01);
    chk("t1 d0", int'(bus.dataout), 8'h01);
    cycle(0, 0, 2'b01);
    chk("t1 d1", int'(bus.dataout), 8'h03);
    cycle(0, 0, 2'b10);
    chk("t1 d2", int'(bus.dataout), 8'h82);
    cycle(0, 0, 2'b10);
    chk("t1 d3 flow", int'(bus.dout_flow), 1);
    chk("t1 empty", int'(bus.empty), 3);

    // Per-flow cap then global full
    for (int i = 0; i < 6; i++) cycle(1, 8'h10 + 8'(i), 0);
    chk("t2 flow_full", int'(bus.flow_full), 1);
    cycle(1, 8'h16, 0);
    chk("t2 cap drop", int'(bus.wr_drop), 1);
    chk("t2 count6", int'(bus.count), 6);
    cycle(1, 8'h90, 0); cycle(1, 8'h91, 0);
    chk("t2 full", int'(bus.full), 1);
    chk("t2 count8", int'(bus.count), 8);
    cycle(1, 8'h92, 0);
    chk("t2 full drop", int'(bus.wr_drop), 1);

    // No same-cycle bypass when full
    cycle(1, 8'h93, 2'b01);
    chk("t3 drop", int'(bus.wr_drop), 1);
    chk("t3 data", int'(bus.dataout), 8'h10);
    chk("t3 count7", int'(bus.count), 7);
    cycle(1, 8'h93, 0);
    chk("t3 accept", int'(bus.wr_drop), 0);
    chk("t3 count8", int'(bus.count), 8);

    // Priority to the highest flow, and no read of an empty flow
    cycle(0, 0, 2'b11);
    chk("t4 flow", int'(bus.dout_flow), 1);
    chk("t4 data", int'(bus.dataout), 8'h90);
    chk("t4 count", int'(bus.count), 7);
    chk("t4 flow_full", int'(bus.flow_full), 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 2'b01);
    chk("t4 last0", int'(bus.dataout), 8'h15);
    chk("t4 empty", int'(bus.empty), 1);
    cycle(0, 0, 2'b01);
    chk("t4 no valid", int'(bus.dout_valid), 0);
    chk("t4 hold", int'(bus.dataout), 8'h15);

    // Randomised traffic: write-heavy half then balanced half
    for (int n = 0; n < 10000; n++) begin
      if (n < 5000)
        cycle($urandom_range(0, 3) != 0, 8'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
      else
        cycle($urandom_range(0, 1) == 1, 8'($urandom), 2'($urandom));
      if (n % 500 == 0) chk("t5 count", int'(bus.count), q0.size() + q1.size());
    end
    chk("t5 wraps>=100", int'(wraps >= 100), 1);

    // Asynchronous reset in the middle of traffic
    cycle(1, 8'h07, 0);
    cycle(0, 0, 2'b01);
    chk("t6 pre valid", int'(bus.dout_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6 valid", int'(bus.dout_valid), 0);
    chk("t6 count", int'(bus.count), 0);
    chk("t6 empty", int'(bus.empty), 3);
    chk("t6 full", int'(bus.full), 0);
    chk("t6 dataout", int'(bus.dataout), 0);
    q0.delete();
    q1.delete();
    sq.delete();
    #3 rst = 1'b1;
    @(negedge ck);
    cycle(1, 8'h05, 0);
    cycle(0, 0, 2'b01);
    chk("t6 data", int'(bus.dataout), 8'h05);
    chk("t6 flow", int'(bus.dout_flow), 0);
    cycle(0, 0, 2'b01);
    chk("t6 no stale", int'(bus.dout_valid), 0);
    chk("t6 drained", sq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
